// File: rtl/register_file_2r1w_if.sv
// Bus bundle for register_file_2r1w: write port, reservation port and two read ports.
// The decode/writeback side uses the master modport; the register file uses the slave modport.
interface register_file_2r1w_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  busy_a;
    logic                  busy_b;

    modport master (
        output we, write_addr, write_data, rsv_en, rsv_addr, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b, busy_a, busy_b
    );

    modport slave (
        input  we, write_addr, write_data, rsv_en, rsv_addr, read_addr_a, read_addr_b,
        output read_data_a, read_data_b, busy_a, busy_b
    );
endinterface

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register file with per-register busy scoreboard and optional zero register.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module register_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    register_file_2r1w_if.slave   bus
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]      busy_r;
    logic [DEPTH-1:0]      busy_nxt_s;
    logic                  wr_ok_s;
    logic                  rsv_ok_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s [2];
    logic [DATA_WIDTH-1:0] rd_data_s [2];
    logic                  rd_busy_s [2];

    // Qualify write and reserve: register 0 swallows both when hardwired to zero
    always_comb begin
        wr_ok_s  = bus.we;
        rsv_ok_s = bus.rsv_en;
        if (ZERO_EN && (bus.write_addr == {ADDR_WIDTH{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = bus.we;
        end
        if (ZERO_EN && (bus.rsv_addr == {ADDR_WIDTH{1'b0}})) begin
            rsv_ok_s = 1'b0;
        end else begin
            rsv_ok_s = bus.rsv_en;
        end
    end

    // Next busy vector: a reservation outranks a same-address write since it names a newer producer
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_ok_s && (bus.rsv_addr == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_ok_s && (bus.write_addr == ADDR_WIDTH'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Register storage and scoreboard state; reset overrides any write or reservation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_r[bus.write_addr] <= bus.write_data;
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Combinational read ports, both served by the same selection logic
    always_comb begin
        rd_addr_s[0] = bus.read_addr_a;
        rd_addr_s[1] = bus.read_addr_b;
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = {DATA_WIDTH{1'b0}};
            rd_busy_s[p] = 1'b0;
            if (ZERO_EN && (rd_addr_s[p] == {ADDR_WIDTH{1'b0}})) begin
                rd_data_s[p] = {DATA_WIDTH{1'b0}};
                rd_busy_s[p] = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (bus.we && (bus.write_addr == rd_addr_s[p])) begin
                rd_data_s[p] = bus.write_data;
                // A same-cycle reservation keeps the stored busy bit visible
                if (bus.rsv_en && (bus.rsv_addr == rd_addr_s[p])) begin
                    rd_busy_s[p] = busy_r[rd_addr_s[p]];
                end else begin
                    rd_busy_s[p] = 1'b0;
                end
            end
`endif
            else begin
                rd_data_s[p] = regs_r[rd_addr_s[p]];
                rd_busy_s[p] = busy_r[rd_addr_s[p]];
            end
        end
    end

    assign bus.read_data_a = rd_data_s[0];
    assign bus.read_data_b = rd_data_s[1];
    assign bus.busy_a      = rd_busy_s[0];
    assign bus.busy_b      = rd_busy_s[1];

endmodule
